qos_fifo_read_sched: RTL and testbench
======================================

Name: qos_fifo_read_sched

Overview:
- Packet-granular weighted-round-robin (WRR) read scheduler for the QoS queue's per-class input temp FIFOs.
- Each class FIFO owns its own read-pointer block. This scheduler drives their read enables, selecting one class at a time.
- Once a class is granted, it keeps the grant until end-of-packet (EOP), so packets are never interleaved.
- Output feeds the downstream QoS output stage, which applies backpressure through out_ready.

Parameters:
- NUM_Q, 4, number of class FIFOs (2..8).
- WEIGHT_W, 4, width of each per-class weight and credit counter.
- QIDX_W, 2, width of grant index; must equal clog2(NUM_Q).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- q_empty  in  NUM_Q  per-class FIFO empty flags.
- q_eop  in  NUM_Q  per-class EOP flag of the FIFO head word (the word read when rd_en is high).
- cfg_weight  in  NUM_Q*WEIGHT_W  packets per round for each class; slice i is class i. 0 disables the class.
- out_ready  in  1  downstream can accept a word this cycle.
- rd_en  out  NUM_Q  one-hot-or-zero read enables to the class FIFO read pointers.
- grant_valid  out  1  a class currently holds the grant.
- grant_q  out  QIDX_W  index of the granted class.
- pkt_done  out  1  single-cycle pulse on the cycle the EOP word is read.

Behaviour:
- Reset values:
  - state=SELECT; rr_ptr=0; all credits=0.
  - grant_valid=0, grant_q=0, pkt_done=0.
  - rd_en is forced to 0 combinationally while rst=1.
- Eligible class i: q_empty[i]=0, weight[i]!=0, credit[i]!=0.
- State SELECT:
  - If any class is eligible: pick the first eligible class searching from rr_ptr upward, wrapping modulo NUM_Q. Register grant_q=i and grant_valid=1, then go to XFER.
  - Else, if some class has q_empty=0, weight!=0 and credit=0: reload credit[j]=weight[j] for all j. Stay in SELECT, so the decision happens on the following cycle.
  - Else: stay in SELECT; grant_valid=0. The block idles here.
- State XFER (class g):
  - rd_en[g] = out_ready & ~q_empty[g]. All other rd_en bits are 0.
  - If the FIFO runs empty mid-packet: stall with rd_en=0 and keep the grant. Never switch classes mid-packet.
  - On a cycle where rd_en[g]=1 and q_eop[g]=1:
    - pulse pkt_done and decrement credit[g] (saturating at 0);
    - set rr_ptr=(g+1) mod NUM_Q;
    - set grant_valid=0 and go to SELECT.
- Latency:
  - First rd_en is asserted one cycle after SELECT registers the grant.
  - Minimum gap between packets is one SELECT cycle, or two cycles if a reload is needed.
- cfg_weight is sampled only at reload time. Changes take effect on the next round.
- A weight change to 0 while a class holds the grant does not abort the current packet.
- A single-word packet (q_eop=1 on the first read) completes in one XFER cycle.
- rst asserted mid-packet: the grant is dropped at the next edge and no further reads occur. The partial packet is the FIFO owner's concern.
- Exactly one rd_en bit is high at any time, or none. The verification engineer asserts this.

Optional Feature:
- Macro: QOS_STRICT_PRIO_EN.
- Defined: in SELECT, class 0 is chosen whenever q_empty[0]=0 and weight[0]!=0, ignoring its credit and rr_ptr. Class 0 never decrements credit. The other classes use WRR only when class 0 is empty.
- Undefined: pure WRR as described above; class 0 has no special treatment.

Decomposition:
- Shared package qos_pkg holds:
  - the state encoding constants (ST_SELECT, ST_XFER);
  - the NUM_Q/WEIGHT_W defaults;
  - the function to extract weight slice i from cfg_weight.
- One sub-module: qos_rr_pick, a combinational rotate-priority encoder. Inputs: eligible mask and rr_ptr. Outputs: index and found flag.

Test Plan:
- Reset: rst=1 for 2 cycles with all queues non-empty -> rd_en=0, grant_valid=0, pkt_done=0 throughout.
- Basic WRR: weights {1,1,1,1}, all queues holding 1-word packets, out_ready=1 -> grant_q sequence 0,1,2,3, then a reload cycle, then 0,1,2,3. Exactly one pkt_done per grant.
- Weights: weights {3,1,0,2}, all queues non-empty with 2-word packets -> per round, class 0 gets 3 packets, class 1 gets 1, class 2 gets 0, class 3 gets 2. Interleaved order per round: 0,1,3,0,3,0.
- Mid-packet empty: class 1 with a 4-word packet where q_empty[1]=1 for 3 cycles after word 2 -> rd_en[1] is low for those 3 cycles, grant_q stays 1, no other rd_en rises, pkt_done pulses after word 4.
- Backpressure: out_ready toggles every cycle during a 4-word packet -> rd_en high only when out_ready=1. Packet completes in 8 cycles; word count is 4.
- Strict priority (QOS_STRICT_PRIO_EN defined): class 0 refills continuously while class 2 is pending -> class 2 is granted only in a cycle when q_empty[0]=1. A class 0 packet already granted is never preempted.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared types, defaults and helpers for the QoS FIFO read scheduler.
package qos_pkg;

  typedef enum logic {
    ST_SELECT = 1'b0,
    ST_XFER   = 1'b1
  } state_t;

  localparam int NUM_Q_DEF    = 4;
  localparam int WEIGHT_W_DEF = 4;

  // Upper bounds used to size the weight-slice helper for any legal configuration.
  localparam int MAX_Q        = 8;
  localparam int MAX_WEIGHT_W = 16;
  localparam int MAX_CFG_W    = MAX_Q * MAX_WEIGHT_W;

  function automatic logic [MAX_WEIGHT_W-1:0] weight_slice(
    input logic [MAX_CFG_W-1:0] cfg,
    input int                   idx,
    input int                   w
  );
    logic [MAX_WEIGHT_W-1:0] mask;
    mask = (MAX_WEIGHT_W'(1) << w) - MAX_WEIGHT_W'(1);
    return MAX_WEIGHT_W'(cfg >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/qos_rr_pick.sv
// Rotating priority encoder: first set bit of 'eligible' at or above rr_ptr, wrapping.
module qos_rr_pick #(
  parameter int NUM_Q  = 4,
  parameter int QIDX_W = 2
) (
  input  logic [NUM_Q-1:0]  eligible,
  input  logic [QIDX_W-1:0] rr_ptr,
  output logic [QIDX_W-1:0] idx,
  output logic              found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_Q; k++) begin
      if (!found && eligible[(int'(rr_ptr) + k) % NUM_Q]) begin
        idx   = QIDX_W'((int'(rr_ptr) + k) % NUM_Q);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_fifo_read_sched.sv
// Packet-granular WRR read scheduler for the per-class QoS input FIFOs.
// Optional macro QOS_STRICT_PRIO_EN gives class 0 strict priority over the WRR classes.
module qos_fifo_read_sched
  import qos_pkg::*;
#(
  parameter int NUM_Q    = NUM_Q_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int QIDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_Q-1:0]          q_empty,
  input  logic [NUM_Q-1:0]          q_eop,
  input  logic [NUM_Q*WEIGHT_W-1:0] cfg_weight,
  input  logic                      out_ready,
  output logic [NUM_Q-1:0]          rd_en,
  output logic                      grant_valid,
  output logic [QIDX_W-1:0]         grant_q,
  output logic                      pkt_done
);

`ifdef QOS_STRICT_PRIO_EN
  localparam bit STRICT_PRIO = 1'b1;
`else
  localparam bit STRICT_PRIO = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [QIDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [QIDX_W-1:0]   grant_d;
  logic                grant_valid_q, grant_valid_d;
  logic [WEIGHT_W-1:0] credit_q [NUM_Q];
  logic [WEIGHT_W-1:0] credit_d [NUM_Q];
  logic [WEIGHT_W-1:0] weight   [NUM_Q];
  logic [MAX_CFG_W-1:0] cfg_ext;
  logic [NUM_Q-1:0]    eligible;
  logic [NUM_Q-1:0]    reloadable;
  logic [QIDX_W-1:0]   pick_idx;
  logic                pick_found;
  logic                prio0;
  logic                take0;

  assign grant_valid = grant_valid_q;

  always_comb begin
    cfg_ext = '0;
    cfg_ext[NUM_Q*WEIGHT_W-1:0] = cfg_weight;
    for (int i = 0; i < NUM_Q; i++) begin
      weight[i] = WEIGHT_W'(weight_slice(cfg_ext, i, WEIGHT_W));
    end
  end

  // A class with data and a nonzero weight either still has credit (eligible)
  // or has used up its round (reloadable).
  always_comb begin
    eligible   = '0;
    reloadable = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      eligible[i]   = !q_empty[i] && (weight[i] != '0) && (credit_q[i] != '0);
      reloadable[i] = !q_empty[i] && (weight[i] != '0) && (credit_q[i] == '0);
    end
    prio0 = !q_empty[0] && (weight[0] != '0);
    take0 = STRICT_PRIO && prio0;
  end

  qos_rr_pick #(
    .NUM_Q  (NUM_Q),
    .QIDX_W (QIDX_W)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    credit_d      = credit_q;
    rd_en         = '0;
    pkt_done      = 1'b0;

    case (state_q)
      ST_SELECT: begin
        if (take0) begin
          grant_d       = '0;
          grant_valid_d = 1'b1;
          state_d       = ST_XFER;
        end else if (pick_found) begin
          grant_d       = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = ST_XFER;
        end else if (|reloadable) begin
          credit_d = weight;
        end else begin
          grant_valid_d = 1'b0;
        end
      end

      ST_XFER: begin
        // The grant is held across empty or backpressured cycles until EOP is read.
        if (!rst && out_ready && !q_empty[grant_q]) begin
          rd_en[grant_q] = 1'b1;
          if (q_eop[grant_q]) begin
            pkt_done = 1'b1;
            if (!(STRICT_PRIO && grant_q == '0) && credit_q[grant_q] != '0) begin
              credit_d[grant_q] = credit_q[grant_q] - WEIGHT_W'(1);
            end
            rr_ptr_d      = (grant_q == QIDX_W'(NUM_Q - 1)) ? '0 : grant_q + QIDX_W'(1);
            grant_valid_d = 1'b0;
            state_d       = ST_SELECT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SELECT;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      for (int i = 0; i < NUM_Q; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      credit_q      <= credit_d;
    end
  end

endmodule

// File: tb/tb_qos_fifo_read_sched.sv
// Self-checking bench for qos_fifo_read_sched: packet-level FIFO models feed the DUT,
// a behavioural WRR model predicts every output each cycle. Honours QOS_STRICT_PRIO_EN.
module tb_qos_fifo_read_sched;

  localparam int NQ = 4;
  localparam int WW = 4;
  localparam int QW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NQ-1:0]    q_empty;
  logic [NQ-1:0]    q_eop;
  logic [NQ*WW-1:0] cfg_weight;
  logic             out_ready;
  logic [NQ-1:0]    rd_en;
  logic             grant_valid;
  logic [QW-1:0]    grant_q;
  logic             pkt_done;

  qos_fifo_read_sched #(
    .NUM_Q    (NQ),
    .WEIGHT_W (WW),
    .QIDX_W   (QW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .q_empty     (q_empty),
    .q_eop       (q_eop),
    .cfg_weight  (cfg_weight),
    .out_ready   (out_ready),
    .rd_en       (rd_en),
    .grant_valid (grant_valid),
    .grant_q     (grant_q),
    .pkt_done    (pkt_done)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Class FIFO contents: each entry is a packet length; head_pos counts words already read.
  int pkt_len [NQ][$];
  int head_pos [NQ];
  int hide_cnt [NQ];
  int rd_count [NQ];

  int hide_pct;
  int ready_mode;
  int refill_pct;
  int stall_class;
  logic             rst_req;
  logic [NQ*WW-1:0] cfg_w;
  bit strict;

  // Reference scheduler state: which class owns the output (-1 = none), last grant,
  // round-robin start point and packets left in the current round per class.
  int m_owner;
  int m_last;
  int m_rr;
  int m_credit [NQ];

  int done_seq [$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic int modelWeight(input int j);
    return int'((cfg_weight >> (WW * j)) & 4'hF);
  endfunction

  task automatic modelReset();
    m_owner = -1;
    m_last  = 0;
    m_rr    = 0;
    for (int i = 0; i < NQ; i++) m_credit[i] = 0;
  endtask

  // Advance the reference by one clock edge given this cycle's inputs.
  task automatic modelAdvance(input logic [NQ-1:0] e, input bit done_now);
    int  choice;
    bit  need_reload;
    choice      = -1;
    need_reload = 1'b0;
    if (rst) begin
      modelReset();
    end else if (m_owner >= 0) begin
      if (done_now) begin
        if (!(strict && m_owner == 0) && m_credit[m_owner] > 0) m_credit[m_owner]--;
        m_rr    = (m_owner + 1) % NQ;
        m_owner = -1;
      end
    end else begin
      if (strict && !e[0] && modelWeight(0) != 0) choice = 0;
      for (int k = 0; k < NQ; k++) begin
        int c;
        c = (m_rr + k) % NQ;
        if (choice < 0 && !e[c] && modelWeight(c) != 0 && m_credit[c] != 0) choice = c;
      end
      if (choice >= 0) begin
        m_owner = choice;
        m_last  = choice;
      end else begin
        for (int j = 0; j < NQ; j++)
          if (!e[j] && modelWeight(j) != 0 && m_credit[j] == 0) need_reload = 1'b1;
        if (need_reload)
          for (int j = 0; j < NQ; j++) m_credit[j] = modelWeight(j);
      end
    end
  endtask

  // One clock cycle: drive inputs after the edge, check outputs, then update FIFOs and model.
  task automatic applyStimulus();
    logic [NQ-1:0] e;
    logic [NQ-1:0] eo;
    int  exp_rd;
    bit  exp_done;
    bit  hidden;
    int  c;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NQ; i++) begin
      hidden = (hide_cnt[i] > 0) || ($urandom_range(99) < hide_pct);
      if (hide_cnt[i] > 0) hide_cnt[i]--;
      e[i]  = (pkt_len[i].size() == 0) || hidden;
      eo[i] = (pkt_len[i].size() != 0) && (head_pos[i] == pkt_len[i][0] - 1);
    end
    rst        = rst_req;
    cfg_weight = cfg_w;
    q_empty    = e;
    q_eop      = eo;
    case (ready_mode)
      1:       out_ready = cyc[0];
      2:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b1;
    endcase
    #1;

    exp_rd   = 0;
    exp_done = 1'b0;
    if (!rst && m_owner >= 0 && out_ready && !e[m_owner]) begin
      exp_rd   = 1 << m_owner;
      exp_done = eo[m_owner];
    end
    checkOutput("rd_en", 32'(rd_en), exp_rd);
    checkOutput("pkt_done", 32'(pkt_done), 32'(exp_done));
    checkOutput("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) checkOutput("grant_q", 32'(grant_q), m_last);
    checkOutput("rd_en_onehot", 32'($countones(rd_en) <= 1), 1);

    for (int i = 0; i < NQ; i++) if (rd_en[i] === 1'b1) rd_count[i]++;
    if (pkt_done === 1'b1) done_seq.push_back(int'(grant_q));

    if (exp_rd != 0) begin
      head_pos[m_owner]++;
      if (m_owner == stall_class && head_pos[m_owner] == 2) hide_cnt[m_owner] = 3;
      if (exp_done) begin
        void'(pkt_len[m_owner].pop_front());
        head_pos[m_owner] = 0;
      end
    end
    modelAdvance(e, exp_done);

    if ($urandom_range(99) < refill_pct) begin
      c = int'($urandom_range(NQ - 1));
      if (pkt_len[c].size() < 4) pkt_len[c].push_back(int'($urandom_range(4, 1)));
    end
  endtask

  task automatic clearFifos();
    for (int i = 0; i < NQ; i++) begin
      pkt_len[i].delete();
      head_pos[i] = 0;
      hide_cnt[i] = 0;
      rd_count[i] = 0;
    end
  endtask

  task automatic loadClass(input int cls, input int npkt, input int len);
    for (int p = 0; p < npkt; p++) pkt_len[cls].push_back(len);
  endtask

  // Two reset cycles with the queues already loaded; outputs must stay quiet.
  task automatic resetPhase();
    rst_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      if (i > 0) checkOutput("rst_grant_q", 32'(grant_q), 0);
    end
    rst_req = 1'b0;
    done_seq.delete();
    for (int i = 0; i < NQ; i++) rd_count[i] = 0;
  endtask

  task automatic runUntilDone(input int npkt, input int budget);
    int n;
    n = 0;
    while (done_seq.size() < npkt && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("pkt_count", done_seq.size(), npkt);
  endtask

  task automatic checkSeq(input string tag, input int exp_seq[$]);
    for (int i = 0; i < exp_seq.size() && i < done_seq.size(); i++)
      checkOutput(tag, done_seq[i], exp_seq[i]);
  endtask

  initial begin
    int exp_a[$];
    int exp_b[$];
`ifdef QOS_STRICT_PRIO_EN
    strict = 1'b1;
    exp_a  = '{0, 0, 1, 2, 3, 1, 2, 3};
    exp_b  = '{0, 0, 0, 0, 0, 0};
`else
    strict = 1'b0;
    exp_a  = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_b  = '{0, 1, 3, 0, 3, 0};
`endif
    rst         = 1'b1;
    rst_req     = 1'b1;
    cfg_w       = 16'h1111;
    cfg_weight  = cfg_w;
    q_empty     = '1;
    q_eop       = '0;
    out_ready   = 1'b1;
    hide_pct    = 0;
    ready_mode  = 0;
    refill_pct  = 0;
    stall_class = -1;
    modelReset();
    clearFifos();

    // Equal weights, single-word packets: plain rotation with a reload between rounds.
    for (int i = 0; i < NQ; i++) loadClass(i, 2, 1);
    resetPhase();
    runUntilDone(8, 100);
    checkSeq("wrr_seq", exp_a);

    // Weights {3,1,0,2} with two-word packets.
    cfg_w = 16'h2013;
    clearFifos();
    for (int i = 0; i < NQ; i++) loadClass(i, 6, 2);
    resetPhase();
    runUntilDone(6, 200);
    checkSeq("weight_seq", exp_b);

    // Class 1 runs dry for three cycles after its second word.
    cfg_w       = 16'h1111;
    stall_class = 1;
    clearFifos();
    loadClass(1, 1, 4);
    resetPhase();
    runUntilDone(1, 60);
    checkOutput("stall_grant", done_seq.size() > 0 ? done_seq[0] : -1, 1);
    checkOutput("stall_words", rd_count[1], 4);
    stall_class = -1;

    // Downstream ready toggles every cycle during a four-word packet.
    ready_mode = 1;
    clearFifos();
    loadClass(0, 1, 4);
    resetPhase();
    runUntilDone(1, 60);
    checkOutput("bp_words", rd_count[0], 4);
    ready_mode = 0;

`ifdef QOS_STRICT_PRIO_EN
    // Class 0 backlog is drained ahead of a pending class 2 packet.
    clearFifos();
    loadClass(0, 3, 2);
    loadClass(2, 1, 2);
    resetPhase();
    runUntilDone(4, 100);
    checkSeq("prio_seq", '{0, 0, 0, 2});
`endif

    // Randomised traffic, stalls, backpressure, weight changes and a mid-run reset.
    hide_pct   = 10;
    ready_mode = 2;
    refill_pct = 35;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NQ; i++) cfg_w[WW*i +: WW] = 4'($urandom_range(3));
      if (r == 0) begin
        clearFifos();
        resetPhase();
      end
      for (int n = 0; n < 400; n++) begin
        if (n == 200) for (int i = 0; i < NQ; i++) cfg_w[WW*i +: WW] = 4'($urandom_range(3, 1));
        rst_req = (r == 3 && n == 150);
        applyStimulus();
      end
      rst_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "[TB] time limit");
  end

endmodule
